// File: rtl/reservation_station_unit_pkg.sv
// Shared types for the reservation station unit.
//   STATION         - decoded instruction arriving from dispatch
//   CDB             - common data bus broadcast {valid, dest_prf, value}
//   FREE_FUNC_UNITS - per-class free masks from the functional units
//   FUNC_PACKET     - one issue slot toward a functional unit
//   RS_FUNC_PACKET  - all issue slots, grouped by unit class
// Also provides the `N and `NUM_ADDERS widths and the operand wakeup helper.

`ifndef N
`define N 4
`endif

`ifndef NUM_ADDERS
`define NUM_ADDERS 4
`endif

package reservation_station_unit_pkg;

  localparam int NW              = `N;           // dispatch / CDB width
  localparam int NUM_FU          = `NUM_ADDERS;  // slots per unit class
  localparam int RS_SIZE_DEFAULT = 16;
  localparam int PRF_W           = 6;

  typedef enum logic [1:0] {
    ADD    = 2'd0,
    MULT   = 2'd1,
    BRANCH = 2'd2,
    MEM    = 2'd3
  } FU_TYPE;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_BEQ   = 4'd11,
    ALU_LOAD  = 4'd12,
    ALU_STORE = 4'd13
  } ALU_FUNC;

  typedef struct packed {
    logic             valid;
    logic             op1_ready;
    logic [31:0]      op1_value;  // holds the producer tag in [5:0] while not ready
    logic             op2_ready;
    logic [31:0]      op2_value;
    logic [PRF_W-1:0] dest_prf;
    FU_TYPE           fu_type;
    ALU_FUNC          func;
  } STATION;

  typedef struct packed {
    logic             valid;
    logic [PRF_W-1:0] dest_prf;
    logic [31:0]      value;
  } CDB;

  typedef struct packed {
    logic [NUM_FU-1:0] adders_free;
    logic [NUM_FU-1:0] mults_free;
    logic [NUM_FU-1:0] branches_free;
    logic [NUM_FU-1:0] mems_free;
  } FREE_FUNC_UNITS;

  typedef struct packed {
    logic             valid;
    logic [31:0]      op1_value;
    logic [31:0]      op2_value;
    logic [PRF_W-1:0] dest_prf;
    ALU_FUNC          func;
  } FUNC_PACKET;

  typedef struct packed {
    FUNC_PACKET [NUM_FU-1:0] adders;
    FUNC_PACKET [NUM_FU-1:0] mults;
    FUNC_PACKET [NUM_FU-1:0] branches;
    FUNC_PACKET [NUM_FU-1:0] mems;
  } RS_FUNC_PACKET;

  // Capture any CDB broadcast whose tag matches an operand that is still
  // waiting. Already-ready operands are left untouched.
  function automatic STATION wake_station(input STATION st, input CDB [NW-1:0] cdb);
    STATION res;
    res = st;
    for (int c = 0; c < NW; c++) begin
      if (cdb[c].valid) begin
        if (!st.op1_ready && (st.op1_value[PRF_W-1:0] == cdb[c].dest_prf)) begin
          res.op1_ready = 1'b1;
          res.op1_value = cdb[c].value;
        end
        if (!st.op2_ready && (st.op2_value[PRF_W-1:0] == cdb[c].dest_prf)) begin
          res.op2_ready = 1'b1;
          res.op2_value = cdb[c].value;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_unit_issue_select.sv
// rs_issue_select: iterated priority select.
// Walks the slots from index 0 upward; every slot whose free bit is set takes
// the lowest-index request not already taken by a lower slot. The k-th set
// free bit therefore receives the k-th request in ascending order.
//   req   [REQ_W]          - requesting entries
//   free  [SLOT_W]         - available slots
//   grant [SLOT_W][REQ_W]  - one-hot entry per slot, all-zero if nothing granted

module rs_issue_select #(
  parameter int REQ_W  = 16,
  parameter int SLOT_W = 4
) (
  input  logic [REQ_W-1:0]             req,
  input  logic [SLOT_W-1:0]            free,
  output logic [SLOT_W-1:0][REQ_W-1:0] grant
);

  logic [REQ_W-1:0] remaining;
  logic             found;

  always_comb begin
    remaining = req;
    found     = 1'b0;
    grant     = '0;
    for (int s = 0; s < SLOT_W; s++) begin
      found = 1'b0;
      if (free[s]) begin
        for (int r = 0; r < REQ_W; r++) begin
          if (!found && remaining[r]) begin
            grant[s][r]  = 1'b1;
            remaining[r] = 1'b0;
            found        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/reservation_station_unit.sv
// reservation_station_unit: out-of-order issue buffer between dispatch and
// the functional units.
//   clock               - system clock, all state updates on posedge
//   reset               - synchronous, active-high; invalidates every entry
//   dispatched_stations - up to `N new stations per cycle
//   cdb_input           - up to `N result broadcasts used for operand wakeup
//   avail_func_units    - per-class free masks (adders/mults/branches/mems)
//   rs_full             - fewer than `N entries free (from current occupancy)
//   rs_to_func          - combinational issue slots, zero-latency grant
// Optional feature macro: RS_CDB_BYPASS_EN. When defined, an entry whose last
// missing operand arrives on the CDB this cycle may issue this cycle with the
// CDB value forwarded; otherwise it becomes eligible on the following cycle.

module reservation_station_unit
  import reservation_station_unit_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  STATION [NW-1:0]       dispatched_stations,
  input  CDB     [NW-1:0]       cdb_input,
  input  FREE_FUNC_UNITS        avail_func_units,
  output logic                  rs_full,
  output RS_FUNC_PACKET         rs_to_func
);

  localparam int NUM_CLASSES = 4;
  localparam int CNT_W       = $clog2(RS_SIZE + 1);

  STATION entries_reg  [RS_SIZE];
  STATION entries_next [RS_SIZE];
  STATION woken        [RS_SIZE];  // stored entries after this cycle's CDB capture
  STATION issue_view   [RS_SIZE];  // what the issue logic sees this cycle
  STATION disp_woken   [NW];       // incoming stations after CDB capture

  logic [RS_SIZE-1:0]                                valid_vec;
  logic [RS_SIZE-1:0]                                issued;
  logic [RS_SIZE-1:0]                                alloc_req;
  logic [NUM_CLASSES-1:0][RS_SIZE-1:0]               class_elig;
  logic [NUM_CLASSES-1:0][NUM_FU-1:0]                class_free;
  logic [NUM_CLASSES-1:0][NUM_FU-1:0][RS_SIZE-1:0]   class_grant;
  FUNC_PACKET [NUM_CLASSES-1:0][NUM_FU-1:0]          class_pkt;
  logic [NW-1:0]                                     disp_req;
  logic [NW-1:0][RS_SIZE-1:0]                        alloc_grant;
  logic [CNT_W-1:0]                                  free_count;

  // Per-entry wakeup and issue view
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign woken[gi]     = wake_station(entries_reg[gi], cdb_input);
      assign valid_vec[gi] = entries_reg[gi].valid;
`ifdef RS_CDB_BYPASS_EN
      assign issue_view[gi] = woken[gi];
`else
      assign issue_view[gi] = entries_reg[gi];
`endif
    end

    for (gi = 0; gi < NW; gi++) begin : g_disp
      assign disp_woken[gi] = wake_station(dispatched_stations[gi], cdb_input);
      // A full station drops the whole dispatch group.
      assign disp_req[gi]   = dispatched_stations[gi].valid & ~rs_full;
    end
  endgenerate

  // Occupancy
  always_comb begin
    free_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!entries_reg[i].valid) begin
        free_count = free_count + 1'b1;
      end
    end
  end

  assign rs_full = (free_count < CNT_W'(NW));

  // Eligibility per unit class
  always_comb begin
    class_elig = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        class_elig[c][i] = issue_view[i].valid && issue_view[i].op1_ready &&
                           issue_view[i].op2_ready &&
                           (2'(issue_view[i].fu_type) == 2'(c));
      end
    end
  end

  assign class_free[0] = avail_func_units.adders_free;
  assign class_free[1] = avail_func_units.mults_free;
  assign class_free[2] = avail_func_units.branches_free;
  assign class_free[3] = avail_func_units.mems_free;

  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_class_sel
      rs_issue_select #(
        .REQ_W  (RS_SIZE),
        .SLOT_W (NUM_FU)
      ) u_issue_select (
        .req   (class_elig[gi]),
        .free  (class_free[gi]),
        .grant (class_grant[gi])
      );
    end
  endgenerate

  // Slot packets: AND-OR of the one-hot grant; ungranted slots stay all-zero.
  always_comb begin
    class_pkt = '0;
    issued    = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int s = 0; s < NUM_FU; s++) begin
        for (int r = 0; r < RS_SIZE; r++) begin
          if (class_grant[c][s][r]) begin
            class_pkt[c][s].valid     = 1'b1;
            class_pkt[c][s].op1_value = issue_view[r].op1_value;
            class_pkt[c][s].op2_value = issue_view[r].op2_value;
            class_pkt[c][s].dest_prf  = issue_view[r].dest_prf;
            class_pkt[c][s].func      = issue_view[r].func;
            issued[r]                 = 1'b1;
          end
        end
      end
    end
  end

  assign rs_to_func.adders   = class_pkt[0];
  assign rs_to_func.mults    = class_pkt[1];
  assign rs_to_func.branches = class_pkt[2];
  assign rs_to_func.mems     = class_pkt[3];

  // Allocation: entries leaving this cycle are reusable immediately, so the
  // free pool includes them. Each valid dispatch lane takes the next lowest.
  assign alloc_req = ~valid_vec | issued;

  rs_issue_select #(
    .REQ_W  (RS_SIZE),
    .SLOT_W (NW)
  ) u_alloc_select (
    .req   (alloc_req),
    .free  (disp_req),
    .grant (alloc_grant)
  );

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_next[i] = woken[i];
      if (issued[i]) begin
        entries_next[i].valid = 1'b0;
      end
    end
    // A new station overrides whatever the slot held (including an issuing entry).
    for (int d = 0; d < NW; d++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (alloc_grant[d][i]) begin
          entries_next[i] = disp_woken[d];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_reg[i] <= entries_next[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_unit.sv
// Self-checking bench for reservation_station_unit: a table of single-entry
// issue vectors followed by hand-written multi-cycle sequences. Expected
// issue packets are pushed to a scoreboard queue as stimulus is driven and
// popped when the issue slots are compared.

module tb_reservation_station_unit;
  import reservation_station_unit_pkg::*;

  logic             clock;
  logic             reset;
  STATION [NW-1:0]  dispatched_stations;
  CDB     [NW-1:0]  cdb_input;
  FREE_FUNC_UNITS   avail_func_units;
  logic             rs_full;
  RS_FUNC_PACKET    rs_to_func;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cls;
    int         slot;
    FUNC_PACKET pkt;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    FU_TYPE      fu;
    logic [3:0]  free;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  dest;
    ALU_FUNC     func;
    int          exp_slot;
  } vec_t;

  vec_t vecs [6];

  reservation_station_unit dut (
    .clock               (clock),
    .reset               (reset),
    .dispatched_stations (dispatched_stations),
    .cdb_input           (cdb_input),
    .avail_func_units    (avail_func_units),
    .rs_full             (rs_full),
    .rs_to_func          (rs_to_func)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic STATION mk_station(input FU_TYPE fu, input logic r1, input logic [31:0] v1,
                                        input logic r2, input logic [31:0] v2,
                                        input logic [5:0] dest, input ALU_FUNC fn);
    STATION st;
    st.valid     = 1'b1;
    st.op1_ready = r1;
    st.op1_value = v1;
    st.op2_ready = r2;
    st.op2_value = v2;
    st.dest_prf  = dest;
    st.fu_type   = fu;
    st.func      = fn;
    return st;
  endfunction

  function automatic FUNC_PACKET mk_pkt(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] dest, input ALU_FUNC fn);
    FUNC_PACKET p;
    p.valid     = 1'b1;
    p.op1_value = a;
    p.op2_value = b;
    p.dest_prf  = dest;
    p.func      = fn;
    return p;
  endfunction

  function automatic FUNC_PACKET get_pkt(input int c, input int s);
    FUNC_PACKET p;
    case (c)
      0:       p = rs_to_func.adders[s];
      1:       p = rs_to_func.mults[s];
      2:       p = rs_to_func.branches[s];
      default: p = rs_to_func.mems[s];
    endcase
    return p;
  endfunction

  task automatic expect_issue(input int cls, input int slot, input FUNC_PACKET p);
    exp_t e;
    e.cls  = cls;
    e.slot = slot;
    e.pkt  = p;
    sb_q.push_back(e);
  endtask

  task automatic set_mask(input int cls, input logic [3:0] m);
    case (cls)
      0:       avail_func_units.adders_free   = m;
      1:       avail_func_units.mults_free    = m;
      2:       avail_func_units.branches_free = m;
      default: avail_func_units.mems_free     = m;
    endcase
  endtask

  task automatic clear_inputs();
    dispatched_stations = '0;
    cdb_input           = '0;
    avail_func_units    = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drain the scoreboard into a slot map, then compare every slot.
  task automatic check_issue(input string name);
    FUNC_PACKET want [4][4];
    FUNC_PACKET got;
    exp_t e;
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++)
        want[c][s] = '0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      want[e.cls][e.slot] = e.pkt;
    end
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 4; s++) begin
        got = get_pkt(c, s);
        checks++;
        if (got !== want[c][s]) begin
          errors++;
          $display("FAIL %s cls=%0d slot=%0d got=%h want=%h", name, c, s, got, want[c][s]);
        end else if (got.valid) begin
          $display("[%0t] %s issue cls=%0d slot=%0d dest=%h op1=%h op2=%h",
                   $time, name, c, s, got.dest_prf, got.op1_value, got.op2_value);
        end
      end
    end
  endtask

  task automatic check_full(input string name, input logic want);
    checks++;
    if (rs_full !== want) begin
      errors++;
      $display("FAIL %s rs_full got=%b want=%b", name, rs_full, want);
    end
  endtask

  initial begin
    vecs[0] = '{ADD,    4'b0001, 32'h0000_0001, 32'h0000_0002, 6'h05, ALU_ADD,  0};
    vecs[1] = '{MULT,   4'b0100, 32'h0000_0007, 32'h0000_0006, 6'h06, ALU_MUL,  2};
    vecs[2] = '{BRANCH, 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'h07, ALU_BEQ,  3};
    vecs[3] = '{MEM,    4'b0110, 32'h1000_0000, 32'h0000_0010, 6'h08, ALU_LOAD, 1};
    vecs[4] = '{ADD,    4'b1100, 32'hFFFF_FFFF, 32'h8000_0000, 6'h3F, ALU_SUB,  2};
    vecs[5] = '{BRANCH, 4'b0011, 32'h0000_0000, 32'h0000_0001, 6'h00, ALU_BEQ,  0};

    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    settle();
    check_full("reset_full", 1'b0);
    check_issue("reset_idle");
    tick();

    // Table: one ready station; dispatched with every unit free it must not
    // issue that cycle, then with only its class mask it lands on the
    // lowest set free bit, and afterwards is gone.
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      dispatched_stations[0] = mk_station(vecs[i].fu, 1'b1, vecs[i].a, 1'b1, vecs[i].b,
                                          vecs[i].dest, vecs[i].func);
      avail_func_units = '1;
      settle();
      check_issue($sformatf("vec%0d_dispatch", i));
      tick();
      clear_inputs();
      set_mask(int'(vecs[i].fu), vecs[i].free);
      expect_issue(int'(vecs[i].fu), vecs[i].exp_slot,
                   mk_pkt(vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].func));
      settle();
      check_issue($sformatf("vec%0d_issue", i));
      tick();
      settle();
      check_issue($sformatf("vec%0d_drained", i));
    end

    // Waiting ADD with no free units
    clear_inputs();
    dispatched_stations[0] = mk_station(ADD, 1'b0, 32'd3, 1'b0, 32'd2, 6'h01, ALU_ADD);
    settle();
    check_issue("t2_dispatch");
    tick();
    clear_inputs();
    settle();
    check_issue("t2_hold");
    check_full("t2_full", 1'b0);

    // Only the fully ready ADD issues
    dispatched_stations[0] = mk_station(ADD, 1'b1, 32'd5, 1'b0, 32'd7, 6'h02, ALU_ADD);
    settle();
    check_issue("t3_disp_a");
    tick();
    dispatched_stations[0] = mk_station(ADD, 1'b1, 32'd3, 1'b1, 32'd4, 6'h03, ALU_ADD);
    settle();
    check_issue("t3_disp_b");
    tick();
    clear_inputs();
    set_mask(0, 4'b0001);
    expect_issue(0, 0, mk_pkt(32'd3, 32'd4, 6'h03, ALU_ADD));
    settle();
    check_issue("t3_issue");
    tick();

    // Wakeup: tag 2 alone is not enough for dest 0x01
    clear_inputs();
    set_mask(0, 4'b1111);
    cdb_input[0].valid    = 1'b1;
    cdb_input[0].dest_prf = 6'd2;
    cdb_input[0].value    = 32'd9;
    settle();
    check_issue("t4_tag2");
    tick();
    cdb_input[0].dest_prf = 6'd3;
    cdb_input[0].value    = 32'h33;
`ifdef RS_CDB_BYPASS_EN
    expect_issue(0, 0, mk_pkt(32'h33, 32'd9, 6'h01, ALU_ADD));
`endif
    settle();
    check_issue("t4_tag3");
    tick();
    cdb_input = '0;
`ifndef RS_CDB_BYPASS_EN
    expect_issue(0, 0, mk_pkt(32'h33, 32'd9, 6'h01, ALU_ADD));
    settle();
    check_issue("t4_tag3_next");
    tick();
`endif
    // Tag 7 wakes stored dest 0x02 and a station dispatched in the same cycle
    cdb_input[0].valid    = 1'b1;
    cdb_input[0].dest_prf = 6'd7;
    cdb_input[0].value    = 32'h77;
    dispatched_stations[0] = mk_station(ADD, 1'b1, 32'h11, 1'b0, 32'd7, 6'h04, ALU_ADD);
`ifdef RS_CDB_BYPASS_EN
    expect_issue(0, 0, mk_pkt(32'd5, 32'h77, 6'h02, ALU_ADD));
`endif
    settle();
    check_issue("t4_tag7");
    tick();
    cdb_input           = '0;
    dispatched_stations = '0;
`ifdef RS_CDB_BYPASS_EN
    expect_issue(0, 0, mk_pkt(32'h11, 32'h77, 6'h04, ALU_ADD));
`else
    expect_issue(0, 0, mk_pkt(32'h11, 32'h77, 6'h04, ALU_ADD));
    expect_issue(0, 1, mk_pkt(32'd5, 32'h77, 6'h02, ALU_ADD));
`endif
    settle();
    check_issue("t4_after");
    tick();
    settle();
    check_issue("t4_empty");

    // Four MULTs then four ADDs, mults on slots 1 and 3 only
    clear_inputs();
    for (int d = 0; d < 4; d++)
      dispatched_stations[d] = mk_station(MULT, 1'b1, 32'(d), 1'b1, 32'(d + 100),
                                          6'(8'h10 + d), ALU_MUL);
    settle();
    check_issue("t5_disp_mult");
    tick();
    for (int d = 0; d < 4; d++)
      dispatched_stations[d] = mk_station(ADD, 1'b1, 32'(d + 20), 1'b1, 32'(d + 40),
                                          6'(8'h20 + d), ALU_ADD);
    settle();
    check_issue("t5_disp_add");
    tick();
    clear_inputs();
    set_mask(1, 4'b1010);
    expect_issue(1, 1, mk_pkt(32'd0, 32'd100, 6'h10, ALU_MUL));
    expect_issue(1, 3, mk_pkt(32'd1, 32'd101, 6'h11, ALU_MUL));
    settle();
    check_issue("t5_mult_a");
    tick();
    expect_issue(1, 1, mk_pkt(32'd2, 32'd102, 6'h12, ALU_MUL));
    expect_issue(1, 3, mk_pkt(32'd3, 32'd103, 6'h13, ALU_MUL));
    settle();
    check_issue("t5_mult_b");
    tick();
    clear_inputs();
    set_mask(0, 4'b1111);
    for (int s = 0; s < 4; s++)
      expect_issue(0, s, mk_pkt(32'(s + 20), 32'(s + 40), 6'(8'h20 + s), ALU_ADD));
    settle();
    check_issue("t5_adds");
    tick();
    settle();
    check_issue("t5_empty");

    // Fill to full, dispatch while full is dropped, then drain
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 4; d++)
        dispatched_stations[d] = mk_station(ADD, 1'b1, 32'(k * 4 + d), 1'b1, 32'd100,
                                            6'(8'h30 + k * 4 + d), ALU_ADD);
      settle();
      check_full($sformatf("t6_fill%0d", k), 1'b0);
      check_issue($sformatf("t6_fill%0d", k));
      tick();
    end
    for (int d = 0; d < 4; d++)
      dispatched_stations[d] = mk_station(ADD, 1'b1, 32'hBAD, 1'b1, 32'hBAD, 6'(d), ALU_ADD);
    settle();
    check_full("t6_full", 1'b1);
    check_issue("t6_full");
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      set_mask(0, 4'b1111);
      for (int s = 0; s < 4; s++)
        expect_issue(0, s, mk_pkt(32'(k * 4 + s), 32'd100, 6'(8'h30 + k * 4 + s), ALU_ADD));
      settle();
      check_full($sformatf("t6_drain%0d", k), (k == 0) ? 1'b1 : 1'b0);
      check_issue($sformatf("t6_drain%0d", k));
      tick();
    end
    settle();
    check_full("t6_empty", 1'b0);
    check_issue("t6_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
